bridge_fifo_arbiter: RTL
========================

BRIDGE_FIFO_ARBITER -- requirements
Module: bridge_fifo_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, mid-frame stall cycles (1..255) before a frame is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; clears all state immediately.
REQ-004 fifo0_data, fifo1_data  input  8 each  registered byte output of port FIFO 0/1; valid the cycle after its read strobe.
REQ-005 fifo0_empty, fifo1_empty  input  1 each  port FIFO holds no byte.
REQ-006 fifo0_frame_rdy, fifo1_frame_rdy  input  1 each  port FIFO holds at least one complete frame.
REQ-007 fifo0_read, fifo1_read  output  1 each  one-cycle pop strobe to port FIFO; combinational from registered state and inputs.
REQ-008 out_ready  input  1  sink can accept a byte presented in the next cycle.
REQ-009 out_valid, out_sof, out_eof  output  1 each  byte valid, first payload byte, last payload byte.
REQ-010 out_data  output  8  forwarded payload byte.
REQ-011 out_abort  output  1  one-cycle pulse: current frame truncated.
REQ-012 grant  output  2  one-hot port currently being served; 2'b00 when idle.
REQ-013 port_dis  output  2  sticky per-port disable after an abort.
REQ-014 frames0, frames1  output  16 each  completed-frame counters per port, wrap modulo 2^16.

Function
REQ-015 Frame format in each FIFO: one length byte L, then L payload bytes; length byte is consumed, never forwarded.
REQ-016 States: IDLE, LEN, PAY, LAST; at most one read strobe asserted in any cycle, only to the granted port.
REQ-017 IDLE: when out_ready=1 and at least one port has frame_rdy=1, fifoN_empty=0 and port_dis[N]=0, select a port, assert its read for the length byte and go to LEN.
REQ-018 Selection is round-robin: if both ports qualify, grant the port not served last; last-served register resets to port 1, so port 0 wins first.
REQ-019 LEN: capture fifoN_data as remaining count; L=0 -> return to IDLE, no output, no count change; else go to PAY.
REQ-020 PAY: a read is issued in each cycle with remaining>0, out_ready=1 and fifoN_empty=0; remaining decrements per read.
REQ-021 Every read in PAY yields out_valid=1 exactly one cycle later with out_data=fifoN_data; the sink must accept it unconditionally.
REQ-022 out_sof=1 with the first payload byte; out_eof=1 with the L-th byte; L=1 asserts both on the same byte.
REQ-023 After the read for the last byte, go to LAST; LAST presents the final byte, increments framesN and returns to IDLE; a new grant is possible in the following cycle.
REQ-024 Stall counter (8-bit) clears on every PAY read and on entry to PAY; it increments each PAY cycle with fifoN_empty=1 and remaining>0; cycles blocked only by out_ready=0 do not count.
REQ-025 Stall counter reaching TIMEOUT: out_abort pulses one cycle, port_dis[N] sets, framesN is unchanged, state returns to IDLE; no further out_valid for that frame.
REQ-026 A disabled port is never granted again until reset; its remaining bytes stay in its FIFO.
REQ-027 frame_rdy is sampled only in IDLE; changes during LEN/PAY/LAST are ignored.
REQ-028 grant holds its one-hot value from the IDLE read cycle through the LAST or abort cycle.

Reset
REQ-029 On rst_n=0, immediately: state IDLE; fifo0_read, fifo1_read, out_valid, out_sof, out_eof and out_abort =0; out_data=8'h00; grant=2'b00; port_dis=2'b00; frames0 and frames1 =0; stall counter =0; last-served =port 1.
REQ-030 Reset asserted mid-frame abandons the frame with no eof or abort pulse; operation resumes from IDLE on the first edge after release.

Verification
REQ-031 Port 0 holds L=3 with bytes A1 A2 A3, out_ready=1 -> reads in cycles t, t+2, t+3, t+4; out_valid in t+3..t+5 with sof on A1 and eof on A3; frames0=1.
REQ-032 Both ports ready with L=2 frames after reset -> port 0 served, then port 1, then port 0; grant sequence 01, 10, 01.
REQ-033 out_ready toggles 1/0 during an L=4 frame -> no read while out_ready=0; all 4 bytes delivered in order; no abort.
REQ-034 Port 1 frame L=5 with FIFO empty after byte 2 for TIMEOUT cycles -> out_abort pulse, port_dis=2'b10, frames1 unchanged, port 0 traffic continues.
REQ-035 L=0 header, then L=1 frame 5A -> first produces no output; second gives one byte 5A with sof=eof=1; frames count=1.
REQ-036 rst_n pulsed low during PAY -> all outputs reach reset values within the same cycle; next frame forwards normally from its length byte.

Source files
------------

// File: rtl/bridge_fifo_arbiter.sv
// Round-robin bridge: pulls length-prefixed frames from two port FIFOs and
// forwards their payload bytes to a single sink, aborting frames that stall.
module bridge_fifo_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  fifo0_data,
    input  logic [7:0]  fifo1_data,
    input  logic        fifo0_empty,
    input  logic        fifo1_empty,
    input  logic        fifo0_frame_rdy,
    input  logic        fifo1_frame_rdy,
    output logic        fifo0_read,
    output logic        fifo1_read,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic [7:0]  out_data,
    output logic        out_abort,
    output logic [1:0]  grant,
    output logic [1:0]  port_dis,
    output logic [15:0] frames0,
    output logic [15:0] frames1
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] STALL_LAST = DW'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {IDLE, LEN, PAY, LAST} state_t;

    state_t        state;
    state_t        state_next;
    logic          sel_q;
    logic          last_q;
    logic          first_q;
    logic [DW-1:0] remaining;
    logic [DW-1:0] stall;
    logic [1:0]    grant_q;

    logic          q0_c;
    logic          q1_c;
    logic          pick1_c;
    logic          port_c;
    logic          empty_c;
    logic          rd_c;
    logic          start_c;
    logic          pay_rd_c;
    logic          abort_c;
    logic [DW-1:0] data_c;

    // Bytes arrive registered from the FIFO, so the presented byte is the
    // currently selected FIFO output gated by the registered valid.
    assign data_c     = sel_q ? fifo1_data : fifo0_data;
    assign out_data   = out_valid ? data_c : '0;
    assign fifo0_read = rd_c & ~port_c;
    assign fifo1_read = rd_c & port_c;
    assign grant      = grant_q | (start_c ? (pick1_c ? 2'b10 : 2'b01) : 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        rd_c       = 1'b0;
        start_c    = 1'b0;
        pay_rd_c   = 1'b0;
        abort_c    = 1'b0;
        q0_c       = fifo0_frame_rdy & ~fifo0_empty & ~port_dis[0];
        q1_c       = fifo1_frame_rdy & ~fifo1_empty & ~port_dis[1];
        pick1_c    = q1_c & (~q0_c | ~last_q);
        port_c     = (state == IDLE) ? pick1_c : sel_q;
        empty_c    = sel_q ? fifo1_empty : fifo0_empty;
        case (state)
            // No new grant during the abort pulse so grant stays with the aborted port.
            IDLE: begin
                if (out_ready && !out_abort && (q0_c || q1_c)) begin
                    start_c    = 1'b1;
                    rd_c       = 1'b1;
                    state_next = LEN;
                end
            end
            LEN: state_next = (data_c == '0) ? IDLE : PAY;
            PAY: begin
                if (!empty_c) begin
                    if (out_ready) begin
                        rd_c     = 1'b1;
                        pay_rd_c = 1'b1;
                        if (remaining == DW'(1)) state_next = LAST;
                    end
                end else if (stall == STALL_LAST) begin
                    abort_c    = 1'b1;
                    state_next = IDLE;
                end
            end
            LAST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            first_q   <= 1'b0;
            remaining <= '0;
            stall     <= '0;
            grant_q   <= 2'b00;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_abort <= 1'b0;
            port_dis  <= 2'b00;
            frames0   <= '0;
            frames1   <= '0;
        end else begin
            out_valid <= pay_rd_c;
            out_sof   <= pay_rd_c & first_q;
            out_eof   <= pay_rd_c & (remaining == DW'(1));
            out_abort <= abort_c;
            if (start_c) begin
                sel_q   <= pick1_c;
                last_q  <= pick1_c;
                grant_q <= pick1_c ? 2'b10 : 2'b01;
            end
            case (state)
                LEN: begin
                    remaining <= data_c;
                    first_q   <= 1'b1;
                    stall     <= '0;
                    if (data_c == '0) grant_q <= 2'b00;
                end
                PAY: begin
                    if (pay_rd_c) begin
                        remaining <= remaining - DW'(1);
                        first_q   <= 1'b0;
                        stall     <= '0;
                    end else if (abort_c) begin
                        port_dis[sel_q] <= 1'b1;
                        stall           <= '0;
                    end else if (empty_c) begin
                        stall <= stall + DW'(1);
                    end
                end
                LAST: begin
                    grant_q <= 2'b00;
                    if (sel_q) frames1 <= frames1 + CW'(1);
                    else       frames0 <= frames0 + CW'(1);
                end
                IDLE: begin
                    if (out_abort) grant_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule
